scoreboard_register_file: RTL

- Parametrised successor to the 8x8 register file of the single-cycle datapath: WIDTH-bit entries, DEPTH entries, two combinational read ports, one write port.
- Adds a per-entry busy scoreboard so multi-cycle producers (memory loads, future multiplier) can reserve a destination register.
- The controller stalls on read-after-write hazards and flags write-after-write reservation errors.
- Sits between the decoder/controller and the ALU operand muxes.

---
 rtl/scoreboard_register_file_pkg.sv | 20 ++
 rtl/scoreboard_register_file_if.sv | 40 ++++
 rtl/scoreboard_register_file_scoreboard.sv | 60 ++++++
 rtl/scoreboard_register_file.sv | 101 ++++++++++
 4 files changed

// File: rtl/scoreboard_register_file_pkg.sv
// rtl/scoreboard_register_file_pkg.sv - shared constants for the scoreboarded register file
package reg_file_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 8;

    localparam logic [DEFAULT_WIDTH-1:0] ZERO_WORD = '0;

    typedef enum logic [2:0] {
        REG0 = 3'd0,
        REG1 = 3'd1,
        REG2 = 3'd2,
        REG3 = 3'd3,
        REG4 = 3'd4,
        REG5 = 3'd5,
        REG6 = 3'd6,
        REG7 = 3'd7
    } reg_idx_e;

endpackage

// File: rtl/scoreboard_register_file_if.sv
// rtl/scoreboard_register_file_if.sv - controller-facing read/write/reserve bundle of the register file
interface scoreboard_register_file_if
    import reg_file_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] SA;
    logic [ADDR_W-1:0] SB;
    logic              USE_A;
    logic              USE_B;
    logic [WIDTH-1:0]  Data_A;
    logic [WIDTH-1:0]  Data_B;
    logic              LD;
    logic [ADDR_W-1:0] DR;
    logic [WIDTH-1:0]  Din;
    logic              RSV;
    logic [ADDR_W-1:0] RSV_DR;
    logic              Busy_A;
    logic              Busy_B;
    logic              Stall;
    logic [DEPTH-1:0]  Busy_mask;
    logic [CNT_W-1:0]  Pending;
    logic              ERR;

    modport master (
        output SA, SB, USE_A, USE_B, LD, DR, Din, RSV, RSV_DR,
        input  Data_A, Data_B, Busy_A, Busy_B, Stall, Busy_mask, Pending, ERR
    );

    modport slave (
        input  SA, SB, USE_A, USE_B, LD, DR, Din, RSV, RSV_DR,
        output Data_A, Data_B, Busy_A, Busy_B, Stall, Busy_mask, Pending, ERR
    );

endinterface

// File: rtl/scoreboard_register_file_scoreboard.sv
// rtl/scoreboard_register_file_scoreboard.sv - per-entry busy bits, pending count and sticky WAW error
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter  int DEPTH  = DEFAULT_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              LD,
    input  logic [ADDR_W-1:0] DR,
    input  logic              RSV,
    input  logic [ADDR_W-1:0] RSV_DR,
    output logic [DEPTH-1:0]  Busy_mask,
    output logic [CNT_W-1:0]  Pending,
    output logic              ERR
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] ld_hit;
    logic [DEPTH-1:0] rsv_hit;
    logic [CNT_W-1:0] pending_q;
    logic             err_q;
    logic             inc;
    logic             dec;
    logic             waw;

    // One-hot decodes; out-of-range indices simply match no entry
    always_comb begin
        ld_hit  = '0;
        rsv_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ld_hit[i]  = LD  && (DR     == ADDR_W'(i));
            rsv_hit[i] = RSV && (RSV_DR == ADDR_W'(i));
        end
    end

    // A same-index write+reserve on a busy entry is net zero: the reservation wins
    assign inc = |(rsv_hit & ~busy_q);
    assign dec = |(ld_hit & busy_q & ~rsv_hit);
    assign waw = |(rsv_hit & busy_q & ~ld_hit);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            busy_q    <= '0;
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            busy_q    <= (busy_q & ~ld_hit) | rsv_hit;
            pending_q <= pending_q + CNT_W'(inc) - CNT_W'(dec);
            err_q     <= err_q | waw;
        end
    end

    assign Busy_mask = busy_q;
    assign Pending   = pending_q;
    assign ERR       = err_q;

endmodule

// File: rtl/scoreboard_register_file.sv
// rtl/scoreboard_register_file.sv - 2R1W register file with busy scoreboard; REGFILE_BYPASS_EN forwards Din to reads
module scoreboard_register_file
    import reg_file_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic CLK,
    input  logic RESET,
    scoreboard_register_file_if.slave rf
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] busy_mask;
    logic [CNT_W-1:0] pending;
    logic             err;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic             busy_a;
    logic             busy_b;

    reg_scoreboard #(.DEPTH(DEPTH)) u_scoreboard (
        .CLK       (CLK),
        .RESET     (RESET),
        .LD        (rf.LD),
        .DR        (rf.DR),
        .RSV       (rf.RSV),
        .RSV_DR    (rf.RSV_DR),
        .Busy_mask (busy_mask),
        .Pending   (pending),
        .ERR       (err)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rf.LD && (rf.DR == ADDR_W'(i))) begin
                    mem[i] <= rf.Din;
                end
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic ld_valid;

    always_comb begin
        ld_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rf.LD && (rf.DR == ADDR_W'(i))) begin
                ld_valid = 1'b1;
            end
        end
    end
`endif

    // Index >= DEPTH matches no entry and therefore reads zero and not busy
    always_comb begin
        data_a = '0;
        data_b = '0;
        busy_a = 1'b0;
        busy_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rf.SA == ADDR_W'(i)) begin
                data_a = mem[i];
                busy_a = busy_mask[i];
            end
            if (rf.SB == ADDR_W'(i)) begin
                data_b = mem[i];
                busy_b = busy_mask[i];
            end
        end
`ifdef REGFILE_BYPASS_EN
        if (ld_valid && (rf.DR == rf.SA)) begin
            data_a = rf.Din;
            busy_a = 1'b0;
        end
        if (ld_valid && (rf.DR == rf.SB)) begin
            data_b = rf.Din;
            busy_b = 1'b0;
        end
`endif
    end

    assign rf.Data_A    = data_a;
    assign rf.Data_B    = data_b;
    assign rf.Busy_A    = busy_a;
    assign rf.Busy_B    = busy_b;
    assign rf.Stall     = (rf.USE_A & busy_a) | (rf.USE_B & busy_b);
    assign rf.Busy_mask = busy_mask;
    assign rf.Pending   = pending;
    assign rf.ERR       = err;

endmodule
